// File: rtl/io_responder.sv
// io_responder: peripheral end of the CPU IO read/write path for the 0xFFFFFCxx window.
// Reads return debounced switch data combinationally. Writes latch the LED register and
// the 7-segment data register. The block also drives a multiplexed 6-digit hex display.
//
// Ports:
//   clock     CPU clock
//   reset     asynchronous, active-low reset
//   io_read   IO read strobe
//   io_write  IO write strobe
//   addr      low 10 bits of the access address
//   io_wdata  CPU write data
//   io_rdata  read data returned to the CPU (combinational)
//   switches  raw board switches (asynchronous)
//   leds      LED drive
//   seg       segments {dp,g..a}, active-low
//   an        digit enables, active-low one-hot; an[7:6] stay high
//
// Configuration macro: IO_READBACK_EN makes the LED and display registers readable.
module io_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned SCAN_DIV        = 16384,
    parameter logic [9:0]  LED_ADDR        = 10'h060,
    parameter logic [9:0]  SW_ADDR         = 10'h070,
    parameter logic [9:0]  SEG_ADDR        = 10'h080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [9:0]  addr,
    input  logic [23:0] io_wdata,
    output logic [23:0] io_rdata,
    input  logic [23:0] switches,
    output logic [23:0] leds,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int unsigned DATA_W  = 24;
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV) + 1;
    localparam int unsigned DIGIT_W = 3;

    logic [DATA_W-1:0]  leds_q, leds_d;
    logic [DATA_W-1:0]  seg_reg_q, seg_reg_d;
    logic [DATA_W-1:0]  sync1_q, sync1_d;
    logic [DATA_W-1:0]  sync2_q, sync2_d;
    logic [DATA_W-1:0]  cand_q, cand_d;
    logic [DATA_W-1:0]  sw_stable_q, sw_stable_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         an_q, an_d;

    // Hex nibble to active-low segment pattern, dp off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Next-state logic: register writes, switch debounce, display scan.
    always_comb begin
        leds_d      = leds_q;
        seg_reg_d   = seg_reg_q;
        sync1_d     = switches;
        sync2_d     = sync1_q;
        cand_d      = cand_q;
        sw_stable_d = sw_stable_q;
        cnt_d       = cnt_q;
        scan_d      = scan_q;
        digit_d     = digit_q;
        seg_d       = seg_q;
        an_d        = an_q;

        if (io_write) begin
            if (addr == LED_ADDR) begin
                leds_d = io_wdata;
            end
            if (addr == SEG_ADDR) begin
                seg_reg_d = io_wdata;
            end
        end

        // Any change of the synchronised value restarts the stability count.
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            sw_stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Digit and its segment pattern update together only at a slot boundary,
        // so a new display value shows up at the next refresh without restarting the scan.
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d  = '0;
            digit_d = (digit_q == DIGIT_W'(5)) ? '0 : digit_q + DIGIT_W'(1);
            an_d    = ~(8'h01 << digit_d);
            seg_d   = hex_to_seg(seg_reg_q[{digit_d, 2'b00} +: 4]);
        end else begin
            scan_d = scan_q + SCAN_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            leds_q      <= '0;
            seg_reg_q   <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            sw_stable_q <= '0;
            cnt_q       <= '0;
            scan_q      <= '0;
            digit_q     <= '0;
            seg_q       <= 8'hC0;
            an_q        <= 8'hFE;
        end else begin
            leds_q      <= leds_d;
            seg_reg_q   <= seg_reg_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cand_q      <= cand_d;
            sw_stable_q <= sw_stable_d;
            cnt_q       <= cnt_d;
            scan_q      <= scan_d;
            digit_q     <= digit_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    // Zero-latency read mux for the single-cycle CPU.
    always_comb begin
        io_rdata = '0;
        if (io_read) begin
            if (addr == SW_ADDR) begin
                io_rdata = sw_stable_q;
            end
`ifdef IO_READBACK_EN
            else if (addr == LED_ADDR) begin
                io_rdata = leds_q;
            end else if (addr == SEG_ADDR) begin
                io_rdata = seg_reg_q;
            end
`endif
        end
    end

    assign leds = leds_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed steps plus randomized traffic against a behavioural model.
module tb_io_responder;

    localparam int unsigned DEB  = 4;
    localparam int unsigned SCAN = 2;

    logic        clock;
    logic        reset;
    logic        io_read;
    logic        io_write;
    logic [9:0]  addr;
    logic [23:0] io_wdata;
    logic [23:0] io_rdata;
    logic [23:0] switches;
    logic [23:0] leds;
    logic [7:0]  seg;
    logic [7:0]  an;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [23:0] m_leds;
    logic [23:0] m_seg_reg;
    logic [23:0] m_stable;
    logic [7:0]  m_an;
    logic [7:0]  m_seg;
    int          e;
    logic [23:0] samp[$];

    io_responder #(
        .DEBOUNCE_CYCLES(DEB),
        .SCAN_DIV       (SCAN),
        .LED_ADDR       (10'h060),
        .SW_ADDR        (10'h070),
        .SEG_ADDR       (10'h080)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .io_read (io_read),
        .io_write(io_write),
        .addr    (addr),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .switches(switches),
        .leds    (leds),
        .seg     (seg),
        .an      (an)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    function automatic logic [7:0] enc(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return t[n];
    endfunction

    function automatic logic [23:0] m_rdata();
        if (!io_read) return 24'h0;
        if (addr == 10'h070) return m_stable;
`ifdef IO_READBACK_EN
        if (addr == 10'h060) return m_leds;
        if (addr == 10'h080) return m_seg_reg;
`endif
        return 24'h0;
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_leds    = 24'h0;
        m_seg_reg = 24'h0;
        m_stable  = 24'h0;
        m_an      = 8'hFE;
        m_seg     = 8'hC0;
        e         = 0;
        samp.delete();
        repeat (DEB + 3) samp.push_back(24'h0);
    endtask

    // One clock edge of the model, using the inputs held across that edge.
    task automatic model_edge();
        int          d;
        int          n;
        logic        same;
        logic [23:0] v;
        e++;
        // Display advances one digit per SCAN clocks, showing the register as it was before this edge.
        if (e % SCAN == 0) begin
            d     = (e / SCAN) % 6;
            m_an  = ~(8'h01 << d);
            m_seg = enc(m_seg_reg[4*d +: 4]);
        end
        // A switch value is accepted once the synchroniser output (two samples late)
        // has held it for DEB+1 consecutive edges.
        samp.push_back(switches);
        if (samp.size() > 32) void'(samp.pop_front());
        n    = samp.size();
        v    = samp[n-3];
        same = 1'b1;
        for (int k = 0; k <= DEB; k++) begin
            if (samp[n-3-k] !== v) same = 1'b0;
        end
        if (same) m_stable = v;
        if (io_write) begin
            if (addr == 10'h060) m_leds = io_wdata;
            if (addr == 10'h080) m_seg_reg = io_wdata;
        end
    endtask

    // Pre-edge read check at the falling edge, then registered outputs just after the rising edge.
    task automatic step();
        @(negedge clock);
        check("io_rdata", io_rdata, m_rdata());
        @(posedge clock);
        model_edge();
        #1;
        check("leds", leds, m_leds);
        check("an", {16'h0, an}, {16'h0, m_an});
        check("seg", {16'h0, seg}, {16'h0, m_seg});
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_leds"}, leds, 24'h0);
        check({tag, "_an"}, {16'h0, an}, 24'h0000FE);
        check({tag, "_seg"}, {16'h0, seg}, 24'h0000C0);
        check({tag, "_rdata"}, io_rdata, 24'h0);
    endtask

    initial begin
        logic found;
        logic [23:0] other;

        reset    = 1'b0;
        io_read  = 1'b1;
        io_write = 1'b0;
        addr     = 10'h070;
        io_wdata = 24'h0;
        switches = 24'h0;
        @(posedge clock);
        #1;
        check_reset_values("reset");
        model_reset();
        #2 reset = 1'b1;

        repeat (3) step();

        // LED write at the LED offset, then an ignored write at a neighbouring offset.
        io_write = 1'b1; addr = 10'h060; io_wdata = 24'hA5A5A5;
        step();
        check("led_write", leds, 24'hA5A5A5);
        addr = 10'h064; io_wdata = 24'h5A5A5A;
        step();
        check("led_bad_addr", leds, 24'hA5A5A5);

        // Clean switch edge: first sampled on the next edge, accepted 6 clocks after that.
        io_write = 1'b0; io_read = 1'b1; addr = 10'h070; switches = 24'h00F00F;
        repeat (6) step();
        check("deb_before", io_rdata, 24'h0);
        step();
        check("deb_after", io_rdata, 24'h00F00F);
        repeat (2) step();

        // Bouncing input never settles long enough.
        for (int i = 0; i < 21; i++) begin
            if (i % 3 == 0) switches = (switches == 24'h00F00F) ? 24'h0F0F00 : 24'h00F00F;
            step();
            check("bounce_hold", io_rdata, 24'h00F00F);
        end
        switches = 24'h00F00F;
        repeat (2) step();

        // Display scan of 123456.
        io_write = 1'b1; addr = 10'h080; io_wdata = 24'h123456;
        step();
        io_write = 1'b0; addr = 10'h070;
        found = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (!found) begin
                step();
                if (an == 8'hFE) found = 1'b1;
            end
        end
        check("scan_found_d0", {23'h0, found}, 24'h1);
        check("scan_d0_seg", {16'h0, seg}, 24'h000082);
        repeat (2) step();
        check("scan_d1_an", {16'h0, an}, 24'h0000FD);
        check("scan_d1_seg", {16'h0, seg}, 24'h000092);
        repeat (8) step();
        check("scan_d5_an", {16'h0, an}, 24'h0000DF);
        check("scan_d5_seg", {16'h0, seg}, 24'h0000F9);
        repeat (2) step();
        check("scan_wrap_an", {16'h0, an}, 24'h0000FE);
        check("scan_wrap_seg", {16'h0, seg}, 24'h000082);

        // Read and write of the LED register in one cycle, then readback.
        io_write = 1'b1; io_read = 1'b1; addr = 10'h060; io_wdata = 24'h000123;
        step();
        io_write = 1'b0;
`ifdef IO_READBACK_EN
        check("readback_led", io_rdata, 24'h000123);
`else
        check("readback_led", io_rdata, 24'h0);
`endif
        step();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            io_write = 1'($urandom_range(0, 1));
            io_read  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: addr = 10'h060;
                1: addr = 10'h064;
                2: addr = 10'h070;
                3: addr = 10'h080;
                default: addr = 10'($urandom());
            endcase
            io_wdata = 24'($urandom());
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: switches = 24'h000000;
                    1: switches = 24'hFFFFFF;
                    default: switches = 24'($urandom());
                endcase
            end
            step();
        end

        // Reset in the middle of a debounce count.
        io_write = 1'b0; io_read = 1'b1; addr = 10'h070;
        other    = ~m_stable;
        switches = other;
        repeat (4) step();
        #1 reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        #1 reset = 1'b1;
        model_reset();
        repeat (6) step();
        check("post_reset_before", io_rdata, 24'h0);
        repeat (3) step();
        check("post_reset_after", io_rdata, other);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
